// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lends the single UART TX byte path to one requester at a time.
// Each grant lasts for one burst, which is followed by an optional idle gap.
module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int GAP_W     = 8,
    parameter int IDW       = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                enable,
    input  logic [GAP_W-1:0]    gap_cycles,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                active,
    output logic [IDW-1:0]      grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               pick_found;
    logic [IDW-1:0]     pick_id;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic [IDW-1:0]     nxt_ptr;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_valid[IDW'((int'(rr_ptr_q) + k) % NREQ)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign nxt_ptr = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                tx_valid = sel_valid;
                tx_data  = sel_valid ? sel_data : 8'h00;
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = (grant_id_q == IDW'(i)) && tx_ready;
                end
                if (sel_valid && tx_ready) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (sel_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        rr_ptr_d = nxt_ptr;
                        if (gap_cycles != '0) begin
                            gap_cnt_d = gap_cycles;
                            state_d   = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (!enable) begin
                    // Abandon the grant only when no byte is mid-handshake.
                    rr_ptr_d = nxt_ptr;
                    state_d  = ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign active   = (state_q == ST_BURST);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-fed requesters, a cycle-level reference model checked
// at every falling edge, plus literal expectations on the transfer log and timing.
module tb_uart_tx_sched;
    localparam int NREQ = 4;
    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  gap;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        active;
    logic [1:0]  grant_id;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(NREQ), .MAX_BURST(MAXB), .GAP_W(8), .IDW(2)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .enable     (enable),
        .gap_cycles (gap),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .active     (active),
        .grant_id   (grant_id)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Requester message queues: bits [7:0] byte, bit 8 = last.
    int q [NREQ][$];
    logic [3:0] mask = 4'h0;
    logic [3:0] acc  = 4'h0;
    int log_g[$], log_d[$], log_c[$];
    int exp_g[$], exp_d[$];

    // Reference model state: owner is -1 when nobody holds the path.
    int m_owner = -1;
    int m_gap   = 0;
    int m_ptr   = 0;
    int m_grant = 0;
    int m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_gap   <= 0;
            m_ptr   <= 0;
            m_grant <= 0;
            m_cnt   <= 0;
        end else if (m_owner >= 0) begin
            if (req_valid[m_owner] && tx_ready) begin
                if (req_last[m_owner] || (m_cnt + 1 == MAXB)) begin
                    m_owner <= -1;
                    m_ptr   <= (m_owner + 1) % NREQ;
                    m_gap   <= int'(gap);
                    m_cnt   <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (!enable) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % NREQ;
                m_gap   <= 0;
            end
        end else if (m_gap > 0) begin
            m_gap <= m_gap - 1;
        end else if (enable && (req_valid != 4'h0)) begin
            m_owner <= rr_pick(m_ptr, req_valid);
            m_grant <= rr_pick(m_ptr, req_valid);
            m_cnt   <= 0;
        end
    end

    task automatic compare();
        logic       e_val;
        logic [7:0] e_data;
        logic [3:0] e_rdy;
        e_val  = 1'b0;
        e_data = 8'h00;
        e_rdy  = 4'h0;
        if (m_owner >= 0) begin
            e_val = req_valid[m_owner];
            if (e_val) e_data = req_data[8*m_owner +: 8];
            if (tx_ready) e_rdy = 4'(1 << m_owner);
        end
        chk("cyc tx_valid", {31'b0, tx_valid}, {31'b0, e_val});
        chk("cyc tx_data", {24'b0, tx_data}, {24'b0, e_data});
        chk("cyc req_ready", {28'b0, req_ready}, {28'b0, e_rdy});
        chk("cyc active", {31'b0, active}, {31'b0, (m_owner >= 0)});
        chk("cyc grant_id", {30'b0, grant_id}, 32'(m_grant));
    endtask

    initial forever begin
        @(negedge clk);
        compare();
        acc = req_valid & req_ready;
        if (tx_valid && tx_ready) begin
            log_g.push_back(int'(grant_id));
            log_d.push_back(int'(tx_data));
            log_c.push_back(cyc);
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic drive();
        int e;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i] && q[i].size() > 0) begin
                e = q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        drive();
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += q[i].size();
        return n;
    endfunction

    task automatic run_empty(input int max_cyc);
        int n = 0;
        while (pending() > 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain bytes left", 32'(pending()), 32'd0);
        repeat (3) step();
    endtask

    task automatic wait_active(input int max_cyc);
        int n = 0;
        while (!active && n < max_cyc) begin
            step();
            n++;
        end
        chk("wait_active", {31'b0, active}, 32'd1);
    endtask

    task automatic expect_xfer(input int g, input int d);
        exp_g.push_back(g);
        exp_d.push_back(d);
    endtask

    task automatic check_log(input string name);
        chk({name, " count"}, 32'(log_g.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < log_g.size(); i++) begin
            chk($sformatf("%s grant[%0d]", name, i), 32'(log_g[i]), 32'(exp_g[i]));
            chk($sformatf("%s data[%0d]", name, i), 32'(log_d[i]), 32'(exp_d[i]));
        end
        exp_g.delete(); exp_d.delete();
        log_g.delete(); log_d.delete(); log_c.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; gap = 8'd0; tx_ready = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst active", {31'b0, active}, 32'd0);
        chk("rst req_ready", {28'b0, req_ready}, 32'd0);
        chk("rst grant_id", {30'b0, grant_id}, 32'd0);
        rst_n = 1'b1;
        step();

        // Round-robin fairness, one byte per grant.
        enable = 1'b1; tx_ready = 1'b1; mask = 4'hF;
        q[0] = '{32'h110, 32'h114}; q[1] = '{32'h111}; q[2] = '{32'h112}; q[3] = '{32'h113};
        drive();
        run_empty(60);
        chk("rr spacing 0-1", 32'(log_c[1] - log_c[0]), 32'd2);
        chk("rr spacing 0-4", 32'(log_c[4] - log_c[0]), 32'd8);
        expect_xfer(0, 8'h10); expect_xfer(1, 8'h11); expect_xfer(2, 8'h12);
        expect_xfer(3, 8'h13); expect_xfer(0, 8'h14);
        check_log("rr");

        // Burst cap: 20 bytes split 16 + 4 with one idle cycle between grants.
        for (int i = 0; i < 20; i++) q[1].push_back(i | ((i == 19) ? 32'h100 : 32'h0));
        drive();
        run_empty(80);
        chk("cap back-to-back", 32'(log_c[15] - log_c[0]), 32'd15);
        chk("cap regrant spacing", 32'(log_c[16] - log_c[15]), 32'd2);
        for (int i = 0; i < 20; i++) expect_xfer(1, i);
        check_log("cap");

        // Gap of 3: 3 GAP + 1 IDLE cycle between bytes; pointer now sits at 2.
        gap = 8'd3;
        q[0] = '{32'h130}; q[2] = '{32'h132};
        drive();
        run_empty(40);
        repeat (6) step();
        chk("gap spacing", 32'(log_c[1] - log_c[0]), 32'd5);
        expect_xfer(2, 8'h32); expect_xfer(0, 8'h30);
        check_log("gap");

        // Backpressure on requester 3.
        gap = 8'd0; tx_ready = 1'b0;
        q[3] = '{32'h1A5};
        drive();
        wait_active(10);
        repeat (5) step();
        chk("bp tx_valid", {31'b0, tx_valid}, 32'd1);
        chk("bp tx_data", {24'b0, tx_data}, 32'hA5);
        chk("bp req_ready", {28'b0, req_ready}, 32'd0);
        chk("bp grant_id", {30'b0, grant_id}, 32'd3);
        tx_ready = 1'b1;
        run_empty(20);
        expect_xfer(3, 8'hA5);
        check_log("bp");

        // Enable drop mid-burst of requester 2; next search starts at 3.
        mask = 4'b0100; tx_ready = 1'b0;
        q[2] = '{32'h050, 32'h151}; q[1] = '{32'h161}; q[3] = '{32'h163};
        drive();
        wait_active(10);
        chk("en grant_id", {30'b0, grant_id}, 32'd2);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0; enable = 1'b0;
        step();
        chk("en drop active", {31'b0, active}, 32'd0);
        chk("en drop req_ready", {28'b0, req_ready}, 32'd0);
        chk("en drop tx_valid", {31'b0, tx_valid}, 32'd0);
        enable = 1'b1; mask = 4'hF; tx_ready = 1'b1;
        drive();
        run_empty(40);
        expect_xfer(2, 8'h50); expect_xfer(3, 8'h63);
        expect_xfer(1, 8'h61); expect_xfer(2, 8'h51);
        check_log("en");

        // Asynchronous reset between clock edges during a burst of requester 3.
        q[3] = '{32'h0B0, 32'h0B1, 32'h1B2};
        drive();
        wait_active(10);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("arst active", {31'b0, active}, 32'd0);
        chk("arst req_ready", {28'b0, req_ready}, 32'd0);
        q[0] = '{32'h1C0}; q[1] = '{32'h1C1};
        drive();
        step();
        step();
        rst_n = 1'b1;
        run_empty(40);
        expect_xfer(3, 8'hB0); expect_xfer(0, 8'hC0); expect_xfer(1, 8'hC1);
        expect_xfer(3, 8'hB1); expect_xfer(3, 8'hB2);
        check_log("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
